// File: rtl/reflet_power_pkg.sv
// reflet_power_pkg
//   Shared definitions for the Reflet power controller: FSM state encoding,
//   register index constants and CTRL/CAUSE bit positions.
//   Optional feature macro: REFLET_POWER_TIMEOUT_EN (see reflet_power_ctrl).
package reflet_power_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        WAKE  = 2'd2
    } power_state_t;

    // Register indices (addr[2:0])
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_MASK     = 3'd1;
    localparam logic [2:0] REG_CAUSE    = 3'd2;
    localparam logic [2:0] REG_KEEP     = 3'd3;
    localparam logic [2:0] REG_TIMEOUT0 = 3'd4;

    // CTRL / CAUSE bit positions
    localparam int CTRL_SLEEP_BIT    = 0;
    localparam int CTRL_TO_EN_BIT    = 1;
    localparam int CTRL_ABORT_BIT    = 6;
    localparam int CAUSE_TIMEOUT_BIT = 7;

    // Indices 4..7 all map onto the little-endian TIMEOUT bytes.
    function automatic logic is_timeout_reg(input logic [2:0] idx);
        return idx[2];
    endfunction

endpackage

// File: rtl/reflet_power_timeout.sv
// reflet_power_timeout
//   Sleep-duration counter: cleared on request, increments while enabled and
//   saturates at all ones. `hit` flags the cycle where the count equals
//   limit-1, so a wake event lands exactly `limit` cycles after the sleep
//   request. A limit of zero never hits.
//
// Ports:
//   clk, reset     system clock, asynchronous active-low reset
//   clear          zero the counter (takes priority over count_en)
//   count_en       increment this cycle
//   limit          programmed TIMEOUT value
//   hit            combinational compare result
module reflet_power_timeout #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             count_en,
    input  logic [width-1:0] limit,
    output logic             hit
);

    localparam logic [width-1:0] one = width'(1);

    logic [width-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create simulation races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + one;
        end
    end

    assign hit = (limit != '0) && (count == (limit - one));

endmodule

// File: rtl/reflet_power_ctrl.sv
// reflet_power_ctrl
//   Power controller on the Reflet byte-wide peripheral bus. Gates the CPU via
//   cpu_enable and up to eight peripheral clock domains, with per-source wake
//   masking, a fixed wake-up delay, a wake-cause register and an optional
//   wake-on-timeout counter.
//
//   Optional feature: define REFLET_POWER_TIMEOUT_EN to include the sleep
//   counter, CTRL.TO_EN, the TIMEOUT registers and CAUSE bit 7. Without it
//   those read 0, ignore writes, and only wake_src can wake the CPU.
//
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   enable, addr    peripheral select and byte address
//   data_in         write data, write_en write strobe
//   data_out        combinational read data, 0 when not selected (OR-bus)
//   wake_src        level wake requests, synchronous to clk
//   cpu_enable      CPU clock enable
//   domain_enable   per-domain clock enables
//   sleeping        high in SLEEP and WAKE
module reflet_power_ctrl
    import reflet_power_pkg::*;
#(
    parameter int                        base_addr_size = 15,
    parameter logic [base_addr_size-1:0] base_addr      = 15'h7F10,
    parameter int                        n_sources      = 4,
    parameter int                        n_domains      = 4,
    parameter int                        timeout_width  = 16,
    parameter int                        wake_delay     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      write_en,
    input  logic [n_sources-1:0]      wake_src,
    output logic                      cpu_enable,
    output logic [n_domains-1:0]      domain_enable,
    output logic                      sleeping
);

    localparam logic [7:0] delay_load = (wake_delay > 0) ? 8'(wake_delay - 1) : 8'd0;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic       wr;
    logic [2:0] idx;

    assign sel = enable && (addr[base_addr_size-1:3] == base_addr[base_addr_size-1:3]);
    assign idx = addr[2:0];
    assign wr  = sel && write_en;

    // ------------------------------------------------------------------
    // Registers and state
    // ------------------------------------------------------------------
    power_state_t         state, state_n;
    logic [7:0]           delay_cnt, delay_n;
    logic [n_sources-1:0] mask;
    logic [n_domains-1:0] keep;
    logic [n_sources-1:0] cause_src;
    logic                 cause_to;
    logic                 abort;
    logic                 to_en;
    logic [31:0]          timeout;   // bytes above timeout_width stay zero
    logic                 to_hit;

    // Wake/abort conditions
    logic [n_sources-1:0] src_pend;
    logic                 in_sleep;
    logic                 wake_pend;
    logic                 sleep_req;
    logic                 go_sleep;
    logic                 set_abort;

    assign src_pend  = wake_src & mask;
    assign in_sleep  = (state == SLEEP);
    assign wake_pend = in_sleep && ((|src_pend) || to_hit);
    assign sleep_req = wr && (idx == REG_CTRL) && data_in[CTRL_SLEEP_BIT];
    // A masked source already active when sleep is requested aborts the sleep.
    assign go_sleep  = (state == RUN) && sleep_req && !(|src_pend);
    assign set_abort = (state == RUN) && sleep_req &&  (|src_pend);

`ifdef REFLET_POWER_TIMEOUT_EN
    logic cnt_hit;

    reflet_power_timeout #(
        .width (timeout_width)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (go_sleep),
        .count_en (in_sleep),
        .limit    (timeout[timeout_width-1:0]),
        .hit      (cnt_hit)
    );

    assign to_hit = to_en && cnt_hit && in_sleep;
`else
    assign to_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            delay_cnt <= '0;
        end else begin
            state     <= state_n;
            delay_cnt <= delay_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n       = state;
        delay_n       = delay_cnt;
        cpu_enable    = 1'b1;
        domain_enable = '1;
        sleeping      = 1'b0;
        case (state)
            RUN: begin
                if (go_sleep) state_n = SLEEP;
            end
            SLEEP: begin
                cpu_enable    = 1'b0;
                domain_enable = keep;
                sleeping      = 1'b1;
                if (wake_pend) begin
                    if (wake_delay == 0) begin
                        state_n = RUN;
                    end else begin
                        state_n = WAKE;
                        delay_n = delay_load;
                    end
                end
            end
            WAKE: begin
                // Domains are already back on; the CPU waits out the delay.
                cpu_enable = 1'b0;
                sleeping   = 1'b1;
                if (delay_cnt == 8'd0) state_n = RUN;
                else                   delay_n = delay_cnt - 8'd1;
            end
            default: state_n = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-visible registers
    // ------------------------------------------------------------------
    logic                 clr_abort;
    logic [n_sources-1:0] clr_src;
    logic                 clr_to;
    logic [n_sources-1:0] set_src;

    assign clr_abort = wr && (idx == REG_CTRL)  && data_in[CTRL_ABORT_BIT];
    assign clr_src   = (wr && (idx == REG_CAUSE)) ? data_in[n_sources-1:0] : '0;
    assign clr_to    = wr && (idx == REG_CAUSE) && data_in[CAUSE_TIMEOUT_BIT];
    assign set_src   = wake_pend ? src_pend : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask      <= '0;
            keep      <= '0;
            cause_src <= '0;
            cause_to  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            if (wr && (idx == REG_MASK)) mask <= data_in[n_sources-1:0];
            if (wr && (idx == REG_KEEP)) keep <= data_in[n_domains-1:0];
            // Sticky flags: a same-cycle set beats the write-1-clear.
            cause_src <= (cause_src & ~clr_src) | set_src;
            cause_to  <= (cause_to & ~clr_to) | (wake_pend && to_hit);
            abort     <= (abort & ~clr_abort) | set_abort;
        end
    end

`ifdef REFLET_POWER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_en   <= 1'b0;
            timeout <= '0;
        end else begin
            if (wr && (idx == REG_CTRL)) to_en <= data_in[CTRL_TO_EN_BIT];
            for (int b = 0; b < 4; b++) begin
                if (wr && is_timeout_reg(idx) && (idx[1:0] == 2'(b)) && (b < timeout_width / 8))
                    timeout[b*8 +: 8] <= data_in;
            end
        end
    end
`else
    assign to_en   = 1'b0;
    assign timeout = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux (combinational, zero when not selected)
    // ------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        if (sel) begin
            case (idx)
                REG_CTRL: begin
                    data_out[CTRL_ABORT_BIT] = abort;
                    data_out[CTRL_TO_EN_BIT] = to_en;
                end
                REG_MASK:  data_out = 8'(mask);
                REG_CAUSE: begin
                    data_out                    = 8'(cause_src);
                    data_out[CAUSE_TIMEOUT_BIT] = cause_to;
                end
                REG_KEEP:  data_out = 8'(keep);
                default:   data_out = timeout[{idx[1:0], 3'b000} +: 8];
            endcase
        end
    end

    // Not every data_in bit lands in a register for every parameter set.
    logic unused_data;
    assign unused_data = ^data_in;

endmodule

// File: tb/tb_reflet_power_ctrl.sv
// tb_reflet_power_ctrl
//   Directed checks from the block's test plan followed by randomized sleep
//   episodes. Expected values come from the block's rules: masked wake sources
//   accumulate into CAUSE, domains return one cycle after the wake event and
//   the CPU after a further wake_delay cycles.
module tb_reflet_power_ctrl;
    import reflet_power_pkg::*;

    localparam int          D    = 4;
    localparam int          TO_T = 100;
    localparam logic [14:0] BASE = 15'h7F10;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic [14:0] addr     = '0;
    logic [7:0]  data_in  = '0;
    logic [7:0]  data_out;
    logic        write_en = 1'b0;
    logic [3:0]  wake_src = '0;
    logic        cpu_enable;
    logic [3:0]  domain_enable;
    logic        sleeping;

    int n_checks = 0;
    int n_pass   = 0;

    reflet_power_ctrl #(
        .base_addr_size (15),
        .base_addr      (BASE),
        .n_sources      (4),
        .n_domains      (4),
        .timeout_width  (16),
        .wake_delay     (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .write_en      (write_en),
        .wake_src      (wake_src),
        .cpu_enable    (cpu_enable),
        .domain_enable (domain_enable),
        .sleeping      (sleeping)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [7:0] d);
        enable   = 1'b1;
        addr     = BASE | 15'(idx);
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        enable   = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [7:0] d);
        enable   = 1'b1;
        addr     = BASE | 15'(idx);
        write_en = 1'b0;
        #1;
        d      = data_out;
        enable = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(idx, d);
        check(tag, d, exp);
    endtask

    // Counts edges until cpu_enable rises (bounded); optional random wake noise.
    task automatic wait_cpu(output int n, input logic noise);
        n = 0;
        while (cpu_enable !== 1'b1 && n < 400) begin
            if (noise) wake_src = 4'($urandom);
            tick();
            n++;
        end
        wake_src = '0;
    endtask

    initial begin
        int         n;
        logic [7:0] d;
        logic       ok;
        logic [3:0] m, k, w, exp_cause;
        int         quiet;

        // ---------------- reset ----------------
        #2 reset = 1'b0;
        #1;
        check("rst_cpu_enable", cpu_enable, 1'b1);
        check("rst_domain_enable", domain_enable, 4'hF);
        check("rst_sleeping", sleeping, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        #20 reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) check_read($sformatf("rst_reg%0d", i), 3'(i), 8'h00);

        // ---------------- masked wake on source 1 ----------------
        bus_write(REG_MASK, 8'h02);
        bus_write(REG_KEEP, 8'h01);
        bus_write(REG_CTRL, 8'h01);
        check("sleep_cpu_enable", cpu_enable, 1'b0);
        check("sleep_domain_enable", domain_enable, 4'h1);
        check("sleep_sleeping", sleeping, 1'b1);
        repeat (19) tick();
        check("sleep_hold_cpu", cpu_enable, 1'b0);
        wake_src = 4'b0010;
        tick();
        wake_src = 4'b0000;
        check("wake_domains_p1", domain_enable, 4'hF);
        check("wake_cpu_p1", cpu_enable, 1'b0);
        wait_cpu(n, 1'b0);
        check("wake_delay_cycles", n, D);
        check("wake_sleeping_off", sleeping, 1'b0);
        check_read("wake_cause", REG_CAUSE, 8'h02);
        check_read("wake_ctrl_sleep_reads0", REG_CTRL, 8'h00);
        bus_write(REG_CAUSE, 8'hFF);
        check_read("cause_w1c", REG_CAUSE, 8'h00);

        // ---------------- abort ----------------
        bus_write(REG_MASK, 8'h01);
        wake_src = 4'b0001;
        bus_write(REG_CTRL, 8'h01);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cpu_enable !== 1'b1 || sleeping !== 1'b0) ok = 1'b0;
            tick();
        end
        check("abort_stays_run", ok, 1'b1);
        check_read("abort_ctrl", REG_CTRL, 8'h40);
        addr = BASE;
        #1;
        check("abort_unselected_read", data_out, 8'h00);
        enable = 1'b1;
        addr   = BASE + 15'd8;
        #1;
        check("abort_other_block_read", data_out, 8'h00);
        enable = 1'b0;
        wake_src = 4'b0000;
        bus_write(REG_CTRL, 8'h40);
        check_read("abort_cleared", REG_CTRL, 8'h00);

        // ---------------- timeout ----------------
`ifdef REFLET_POWER_TIMEOUT_EN
        bus_write(REG_MASK, 8'h00);
        bus_write(3'd4, 8'(TO_T));
        bus_write(3'd5, 8'h00);
        bus_write(3'd6, 8'h55);
        check_read("to_byte0", 3'd4, 8'(TO_T));
        check_read("to_byte2_absent", 3'd6, 8'h00);
        bus_write(REG_CTRL, 8'h03);
        check("to_sleeping", sleeping, 1'b1);
        wait_cpu(n, 1'b0);
        check("to_wake_cycles", n, TO_T + D);
        check_read("to_cause", REG_CAUSE, 8'h80);
        bus_write(REG_CAUSE, 8'hFF);
        bus_write(REG_CTRL, 8'h00);
`else
        bus_write(3'd4, 8'hAB);
        check_read("to_absent_reg4", 3'd4, 8'h00);
        bus_write(REG_CTRL, 8'h02);
        check_read("to_absent_to_en", REG_CTRL, 8'h00);
`endif

        // ---------------- same-cycle set and clear of CAUSE ----------------
        bus_write(REG_MASK, 8'h04);
        bus_write(REG_CTRL, 8'h01);
        tick();
        tick();
        wake_src = 4'b0100;
        bus_write(REG_CAUSE, 8'hFF);
        wake_src = 4'b0000;
        wait_cpu(n, 1'b0);
        check("setclr_delay", n, D);
        check_read("setclr_cause", REG_CAUSE, 8'h04);
        bus_write(REG_CAUSE, 8'hFF);

        // ---------------- reset mid-sleep ----------------
        bus_write(REG_MASK, 8'h08);
        bus_write(REG_KEEP, 8'h03);
        bus_write(REG_CTRL, 8'h01);
        tick();
        tick();
        check("midrst_was_sleeping", sleeping, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midrst_cpu_enable", cpu_enable, 1'b1);
        check("midrst_domain_enable", domain_enable, 4'hF);
        check("midrst_sleeping", sleeping, 1'b0);
        #3 reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) check_read($sformatf("midrst_reg%0d", i), 3'(i), 8'h00);

        // ---------------- randomized episodes ----------------
        for (int e = 0; e < 25; e++) begin
            m = 4'($urandom_range(1, 15));
            k = 4'($urandom);
            bus_write(REG_MASK, {4'($urandom), m});
            bus_write(REG_KEEP, {4'($urandom), k});
            bus_write(REG_CAUSE, 8'hFF);
            check_read("ep_mask", REG_MASK, {4'h0, m});
            check_read("ep_keep", REG_KEEP, {4'h0, k});
            w = 4'($urandom);
            if ($urandom_range(0, 3) != 0) w = w & ~m;
            wake_src = w;
            bus_write(REG_CTRL, 8'h01);
            wake_src = 4'b0000;
            if ((w & m) != 4'h0) begin
                check("ep_abort_cpu", cpu_enable, 1'b1);
                check_read("ep_abort_ctrl", REG_CTRL, 8'h40);
                bus_write(REG_CTRL, 8'h40);
                check_read("ep_abort_clear", REG_CTRL, 8'h00);
                check_read("ep_abort_cause", REG_CAUSE, 8'h00);
            end else begin
                check("ep_sleep_domains", domain_enable, k);
                check("ep_sleep_cpu", cpu_enable, 1'b0);
                quiet = $urandom_range(1, 12);
                ok = 1'b1;
                repeat (quiet) begin
                    wake_src = 4'($urandom) & ~m;
                    tick();
                    if (sleeping !== 1'b1 || cpu_enable !== 1'b0 || domain_enable !== k) ok = 1'b0;
                end
                check("ep_stays_asleep", ok, 1'b1);
                w = 4'($urandom) & m;
                if (w == 4'h0) w = m;
                exp_cause = w;
                wake_src = w | (4'($urandom) & ~m);
                tick();
                check("ep_wake_domains", domain_enable, 4'hF);
                check("ep_wake_cpu_low", cpu_enable, 1'b0);
                wait_cpu(n, 1'b1);
                check("ep_wake_delay", n, D);
                check_read("ep_cause", REG_CAUSE, {4'h0, exp_cause});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
